// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the two-port BRAM arbiter.
package bram_arb_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 16;

   // Requester index: 0 or 1.
   typedef logic req_id_t;

   // One stage of the read-return pipeline: is a read in flight, and whose is it.
   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_pipe_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. A lone requester always wins; with both
// requesting, the one that did not win the last grant goes next.
// The last-winner register is exposed so it can be observed or chained
// into wider arbiters later.
module rr_arbiter2
   import bram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output req_id_t    gnt_id,
   output logic       gnt_any,
   output req_id_t    rr_last
);

   // Pick the winner from the current requests and the last winner.
   always_comb begin
      gnt_id  = 1'b0;
      gnt_any = |req;
      case (req)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~rr_last;
         default: gnt_id = 1'b0;
      endcase
      gnt = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
   end

   // Remember who won; reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!rstn)
         rr_last <= 1'b1;
      else if (gnt_any)
         rr_last <= gnt_id;
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between two requesters.
//
// Request handshake: a transfer happens at the rising edge where
// req_valid[i] & req_ready[i]. req_ready is a combinational function of
// req_valid, so a requester must not derive req_valid from req_ready, and
// must hold its req_* fields stable while valid and not yet ready.
// Reads return on rsp_valid[id] (one-cycle pulse) with rsp_rdata; writes
// produce no response.
//
// Optional build macro BRAM_ARB_RSP_REG_EN: registers rsp_valid/rsp_rdata,
// adding one cycle of read latency (READ_LAT+1 instead of READ_LAT).
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int READ_LAT = 1
)(
   input  logic                clk,
   input  logic                rstn,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [ADDR_W-1:0]   bram_addra,
   output logic [DATA_W-1:0]   bram_dina,
   output logic                bram_wea,
   output logic                bram_ena,
   input  logic [DATA_W-1:0]   bram_douta
);

   logic [1:0] gnt;
   req_id_t    gnt_id;
   logic       gnt_any;
   req_id_t    rr_last;
   logic       xfer;
   req_id_t    sel;
   logic       rd_xfer;
   rd_pipe_t   rd_pipe [READ_LAT];
   rd_pipe_t   rd_out;
   logic [1:0] rsp_valid_c;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req_valid),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any),
      .rr_last (rr_last)
   );

   // Grant and BRAM drive; nothing is granted while reset is held.
   always_comb begin
      xfer       = rstn & gnt_any;
      req_ready  = xfer ? gnt : 2'b00;
      sel        = xfer ? gnt_id : 1'b0;
      bram_ena   = xfer;
      bram_wea   = xfer & req_we[sel];
      bram_addra = req_addr[sel*ADDR_W +: ADDR_W];
      bram_dina  = req_wdata[sel*DATA_W +: DATA_W];
      rd_xfer    = xfer & ~req_we[sel];
   end

   // Track in-flight reads so data goes back to the requester that issued it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < READ_LAT; k++)
            rd_pipe[k] <= '0;
      end else begin
         rd_pipe[0] <= '{valid: rd_xfer, id: sel};
         for (int k = 1; k < READ_LAT; k++)
            rd_pipe[k] <= rd_pipe[k-1];
      end
   end

   // Decode the pipeline tail into a per-requester pulse; silenced in reset.
   always_comb begin
      rd_out      = rd_pipe[READ_LAT-1];
      rsp_valid_c = 2'b00;
      if (rstn && rd_out.valid)
         rsp_valid_c = rd_out.id ? 2'b10 : 2'b01;
   end

`ifdef BRAM_ARB_RSP_REG_EN
   logic [1:0]        rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   // Register the response; data only updates when a read returns.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_c;
         if (|rsp_valid_c)
            rsp_rdata_q <= bram_douta;
      end
   end

   // Registered outputs, with the pulse masked while reset is held.
   always_comb begin
      rsp_valid = rstn ? rsp_valid_q : 2'b00;
      rsp_rdata = rsp_rdata_q;
   end
`else
   // Response goes straight from the BRAM output.
   always_comb begin
      rsp_valid = rsp_valid_c;
      rsp_rdata = bram_douta;
   end
`endif

endmodule
